// File: rtl/tff_ctrl_pkg.sv
// Shared types for the T-flip-flop register controller: FSM states, op codes, round-robin helpers.
// Optional shift operation is enabled with TREG_SHIFT_EN.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, APPLY, ACK} state_e;
  typedef enum logic [1:0] {OP_LD, OP_CNT, OP_SH} op_e;

  localparam op_e RR_RST = OP_LD;

`ifdef TREG_SHIFT_EN
  localparam int NUM_REQ = 3;
`else
  localparam int NUM_REQ = 2;
`endif

  function automatic op_e rr_next(op_e w);
    if (int'(w) == NUM_REQ - 1) return OP_LD;
    else return op_e'(w + 2'd1);
  endfunction

  function automatic logic req_of(logic [NUM_REQ-1:0] req, op_e op);
    logic r = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (op == op_e'(i[1:0])) r = req[i];
    return r;
  endfunction

  // Walk from the favoured requester in round-robin order; first active one wins.
  function automatic op_e rr_pick(logic [NUM_REQ-1:0] req, op_e ptr);
    op_e  cand  = ptr;
    op_e  w     = ptr;
    logic found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_of(req, cand)) begin
        w     = cand;
        found = 1'b1;
      end
      cand = rr_next(cand);
    end
    return w;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop: toggles when t is high, synchronous active-high clear.
module t_ff_cell (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic q_q, q_d;

  always_comb q_d = q_q ^ t;

  always_ff @(posedge clk) begin
    if (clr) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/tff_reg_ctrl.sv
// Round-robin controller turning load/increment requests into toggle vectors for a T-FF register.
// Define TREG_SHIFT_EN to add a third requester (shift right, sh_in enters at the MSB).
module tff_reg_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld_req,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ack,
  input  logic             cnt_req,
  output logic             cnt_ack,
`ifdef TREG_SHIFT_EN
  input  logic             sh_req,
  input  logic             sh_in,
  output logic             sh_ack,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  op_e                rr_q, rr_d;
  logic [WIDTH-1:0]   ld_data_q, ld_data_d;
  logic [WIDTH-1:0]   t_reg_q, t_reg_d;
  logic [NUM_REQ-1:0] req_vec;
  logic [WIDTH-1:0]   t_inc;
  logic               carry;
`ifdef TREG_SHIFT_EN
  logic               sh_in_q, sh_in_d;

  assign req_vec = {sh_req, cnt_req, ld_req};
`else
  assign req_vec = {cnt_req, ld_req};
`endif

  // Increment toggles: bit i flips when all lower bits are 1 (all-ones wraps to zero).
  always_comb begin
    t_inc = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_inc[i] = carry;
      carry    = carry & q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rr_d      = rr_q;
    ld_data_d = ld_data_q;
    t_reg_d   = t_reg_q;
`ifdef TREG_SHIFT_EN
    sh_in_d   = sh_in_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          op_d      = rr_pick(req_vec, rr_q);
          rr_d      = rr_next(op_d);
          ld_data_d = ld_data;
`ifdef TREG_SHIFT_EN
          sh_in_d   = sh_in;
`endif
          state_d   = GRANT;
        end
      end
      GRANT: begin
        case (op_q)
          OP_LD:   t_reg_d = ld_data_q ^ q;
          OP_CNT:  t_reg_d = t_inc;
`ifdef TREG_SHIFT_EN
          OP_SH:   t_reg_d = {sh_in_q, q[WIDTH-1:1]} ^ q;
`endif
          default: t_reg_d = '0;
        endcase
        state_d = APPLY;
      end
      APPLY:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      op_q      <= OP_LD;
      rr_q      <= RR_RST;
      ld_data_q <= '0;
      t_reg_q   <= '0;
`ifdef TREG_SHIFT_EN
      sh_in_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rr_q      <= rr_d;
      ld_data_q <= ld_data_d;
      t_reg_q   <= t_reg_d;
`ifdef TREG_SHIFT_EN
      sh_in_q   <= sh_in_d;
`endif
    end
  end

  // The bank only sees toggles during APPLY, so q changes on APPLY's closing edge.
  assign t_vec   = (state_q == APPLY) ? t_reg_q : '0;
  assign busy    = (state_q != IDLE);
  assign ld_ack  = (state_q == ACK) && (op_q == OP_LD);
  assign cnt_ack = (state_q == ACK) && (op_q == OP_CNT);
`ifdef TREG_SHIFT_EN
  assign sh_ack  = (state_q == ACK) && (op_q == OP_SH);
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk  (clk),
      .clr  (clr),
      .t    (t_vec[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

endmodule

// File: tb/tb_tff_reg_ctrl.sv
// Directed bench for tff_reg_ctrl (WIDTH=4): reset, load, count wrap, arbitration, mid-op clear.
module tb_tff_reg_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       ld_req;
  logic [3:0] ld_data;
  logic       ld_ack;
  logic       cnt_req;
  logic       cnt_ack;
`ifdef TREG_SHIFT_EN
  logic       sh_req;
  logic       sh_in;
  logic       sh_ack;
`endif
  logic [3:0] q, qbar, t_vec;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tff_reg_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .clr     (clr),
    .ld_req  (ld_req),
    .ld_data (ld_data),
    .ld_ack  (ld_ack),
    .cnt_req (cnt_req),
    .cnt_ack (cnt_ack),
`ifdef TREG_SHIFT_EN
    .sh_req  (sh_req),
    .sh_in   (sh_in),
    .sh_ack  (sh_ack),
`endif
    .q       (q),
    .qbar    (qbar),
    .t_vec   (t_vec),
    .busy    (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
  endtask

  // Raise one request, wait (bounded) for its ack, drop it, return to IDLE.
  // op: 0=load, 1=count, 2=shift. lat=-1 if no ack seen.
  task automatic do_op(input int op, input logic [3:0] data, input logic sin,
                       output int lat, output int other_acks);
    logic own, oth;
    lat        = -1;
    other_acks = 0;
    ld_data    = data;
    if (op == 0) ld_req = 1'b1;
    if (op == 1) cnt_req = 1'b1;
`ifdef TREG_SHIFT_EN
    sh_in = sin;
    if (op == 2) sh_req = 1'b1;
`else
    if (sin) other_acks = 0;
`endif
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      step();
      own = (op == 0) ? ld_ack : (op == 1) ? cnt_ack : 1'b0;
      oth = (op == 0) ? cnt_ack : ld_ack;
`ifdef TREG_SHIFT_EN
      if (op == 2) own = sh_ack;
      else oth = oth | sh_ack;
      if (op == 2) oth = ld_ack | cnt_ack;
`endif
      if (oth) other_acks++;
      if (own) lat = c;
    end
    ld_req  = 1'b0;
    cnt_req = 1'b0;
`ifdef TREG_SHIFT_EN
    sh_req  = 1'b0;
`endif
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=0000", q); end
    checks++; if (qbar !== 4'b1111) begin failures++; $display("FAIL reset_qbar got=%b exp=1111", qbar); end
    checks++; if (t_vec !== 4'b0000) begin failures++; $display("FAIL reset_tvec got=%b exp=0000", t_vec); end
    checks++; if ({ld_ack, cnt_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b exp=00", {ld_ack, cnt_ack}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_load();
    ld_data = 4'b1010;
    ld_req  = 1'b1;
    step();  // GRANT
    checks++; if (busy !== 1'b1 || t_vec !== 4'b0000) begin failures++; $display("FAIL load_grant busy=%b tvec=%b exp busy=1 tvec=0000", busy, t_vec); end
    step();  // APPLY
    checks++; if (t_vec !== 4'b1010) begin failures++; $display("FAIL load_tvec got=%b exp=1010", t_vec); end
    checks++; if (ld_ack !== 1'b0 || q !== 4'b0000) begin failures++; $display("FAIL load_apply ack=%b q=%b exp ack=0 q=0000", ld_ack, q); end
    step();  // ACK
    checks++; if (ld_ack !== 1'b1) begin failures++; $display("FAIL load_ack got=%b exp=1", ld_ack); end
    checks++; if (q !== 4'b1010 || qbar !== 4'b0101) begin failures++; $display("FAIL load_q q=%b qbar=%b exp 1010/0101", q, qbar); end
    checks++; if (t_vec !== 4'b0000 || cnt_ack !== 1'b0) begin failures++; $display("FAIL load_ackcyc tvec=%b cnt_ack=%b exp 0000/0", t_vec, cnt_ack); end
    ld_req = 1'b0;
    step();  // IDLE
    checks++; if (ld_ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL load_done ack=%b busy=%b exp 0/0", ld_ack, busy); end
  endtask

  task automatic test_count_wrap();
    logic [3:0] exp_q [4] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001};
    int lat, oth;
    do_op(0, 4'b1101, 1'b0, lat, oth);
    checks++; if (q !== 4'b1101 || lat != 3) begin failures++; $display("FAIL cnt_preload q=%b lat=%0d exp 1101/3", q, lat); end
    for (int n = 0; n < 4; n++) begin
      do_op(1, 4'b0000, 1'b0, lat, oth);
      checks++;
      if (q !== exp_q[n] || lat != 3 || oth != 0) begin
        failures++;
        $display("FAIL cnt_step%0d q=%b lat=%0d other=%0d exp q=%b lat=3 other=0", n, q, lat, oth, exp_q[n]);
      end
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    ld_data = 4'b0110;
    ld_req  = 1'b1;
    cnt_req = 1'b1;
    step(); step(); step();
    checks++; if (ld_ack !== 1'b1 || cnt_ack !== 1'b0 || q !== 4'b0110) begin failures++; $display("FAIL arb_first ld_ack=%b cnt_ack=%b q=%b exp 1/0/0110", ld_ack, cnt_ack, q); end
    ld_req = 1'b0;
    step();  // IDLE, count still pending; load requests again
    ld_data = 4'b1001;
    ld_req  = 1'b1;
    step(); step(); step();
    checks++; if (cnt_ack !== 1'b1 || ld_ack !== 1'b0 || q !== 4'b0111) begin failures++; $display("FAIL arb_second cnt_ack=%b ld_ack=%b q=%b exp 1/0/0111", cnt_ack, ld_ack, q); end
    cnt_req = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || ld_ack !== 1'b0) begin failures++; $display("FAIL arb_idle busy=%b ld_ack=%b exp 0/0", busy, ld_ack); end
    step(); step(); step();
    checks++; if (ld_ack !== 1'b1 || cnt_ack !== 1'b0 || q !== 4'b1001) begin failures++; $display("FAIL arb_third ld_ack=%b cnt_ack=%b q=%b exp 1/0/1001", ld_ack, cnt_ack, q); end
    ld_req = 1'b0;
    step();
  endtask

  task automatic test_clr_mid_op();
    do_reset();
    ld_data = 4'b1111;
    ld_req  = 1'b1;
    step(); step();  // APPLY
    checks++; if (t_vec !== 4'b1111) begin failures++; $display("FAIL clr_apply_tvec got=%b exp=1111", t_vec); end
    clr    = 1'b1;
    ld_req = 1'b0;
    step();
    checks++; if (q !== 4'b0000 || qbar !== 4'b1111) begin failures++; $display("FAIL clr_q q=%b qbar=%b exp 0000/1111", q, qbar); end
    checks++; if (ld_ack !== 1'b0 || busy !== 1'b0 || t_vec !== 4'b0000) begin failures++; $display("FAIL clr_state ack=%b busy=%b tvec=%b exp 0/0/0000", ld_ack, busy, t_vec); end
    clr = 1'b0;
    step();
    checks++; if (ld_ack !== 1'b0 || busy !== 1'b0 || q !== 4'b0000) begin failures++; $display("FAIL clr_after ack=%b busy=%b q=%b exp 0/0/0000", ld_ack, busy, q); end
  endtask

`ifdef TREG_SHIFT_EN
  task automatic test_shift();
    int lat, oth;
    do_reset();
    do_op(0, 4'b1001, 1'b0, lat, oth);
    sh_in  = 1'b1;
    sh_req = 1'b1;
    step(); step();
    checks++; if (t_vec !== 4'b0101) begin failures++; $display("FAIL sh_tvec got=%b exp=0101", t_vec); end
    step();
    checks++; if (q !== 4'b1100 || sh_ack !== 1'b1) begin failures++; $display("FAIL sh_ack q=%b ack=%b exp 1100/1", q, sh_ack); end
    sh_req = 1'b0;
    step();
    checks++; if (sh_ack !== 1'b0) begin failures++; $display("FAIL sh_pulse got=%b exp=0", sh_ack); end
  endtask
`endif

  initial begin
    clr     = 1'b1;
    ld_req  = 1'b0;
    ld_data = 4'b0000;
    cnt_req = 1'b0;
`ifdef TREG_SHIFT_EN
    sh_req  = 1'b0;
    sh_in   = 1'b0;
`endif
    test_reset();
    test_load();
    test_count_wrap();
    test_arbitration();
    test_clr_mid_op();
`ifdef TREG_SHIFT_EN
    test_shift();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
